// File: rtl/flash_map_pkg.sv
// Shared types and constants for the program-flash chip-select map and its responders.
package flash_map_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned CS_W_DEF   = 16;

  localparam int unsigned FLASH0_IDX = 0;
  localparam int unsigned FLASH1_IDX = 1;

  // No chip selected (chip-selects are active-low).
  localparam logic [CS_W_DEF-1:0] CS_NONE = '1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } flash_state_t;

endpackage

// File: rtl/flash_chip_responder_if.sv
// Initiator/responder bus of the active-low chip-select program-flash interface.
interface flash_chip_responder_if
  import flash_map_pkg::*;
#(
  parameter int unsigned CS_W   = CS_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic [CS_W-1:0]   cs_n;
  logic [ADDR_W-1:0] address;
  logic              req;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              busy;
  logic              err;

  modport master (
    output cs_n, address, req, we, wdata,
    input  rdata, ready, busy, err
  );

  modport slave (
    input  cs_n, address, req, we, wdata,
    output rdata, ready, busy, err
  );

endinterface

// File: rtl/flash_wait_counter.sv
// Loadable down-counter for memory-responder wait states; done_c flags the last wait cycle.
module flash_wait_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done_c
);

  logic [CNT_W-1:0] count_q;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done_c = (count_q == CNT_W'(1));

endmodule

// File: rtl/flash_chip_responder.sv
// Chip-side responder modelling one program-flash IC on one bit of the chip-select vector.
// Optional write protect input wp_n is enabled by defining FLASH_WRITE_PROTECT_EN.
module flash_chip_responder
  import flash_map_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned CS_W        = CS_W_DEF,
  parameter int unsigned CS_INDEX    = FLASH0_IDX,
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 3
) (
  input  logic clk,
  input  logic nRESET,
`ifdef FLASH_WRITE_PROTECT_EN
  input  logic wp_n,
`endif
  flash_chip_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CS_W-1:0] IDX_MASK = CS_W'(1) << CS_INDEX;

  flash_state_t state_q, state_d;

  logic [DEPTH_LOG2-1:0] idx_q;
  logic                  we_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  err_q;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic                  sel_c, multi_c, cnt_done_c;
  logic                  latch_c, cnt_load_c, cnt_dec_c, acc_c, err_d;
  logic                  mem_we_c, rd_c, prot_c;
  logic [DEPTH_LOG2-1:0] bus_idx_c, acc_idx_c;
  logic                  acc_we_c;
  logic [DATA_W-1:0]     acc_wdata_c;
  logic                  unused_addr_c;

  // Chip decode: own bit low, and either alone (sel) or with another chip (multi).
  assign sel_c     = !bus.cs_n[CS_INDEX] && ((bus.cs_n | IDX_MASK) == '1);
  assign multi_c   = !bus.cs_n[CS_INDEX] && ((bus.cs_n | IDX_MASK) != '1);
  assign bus_idx_c = bus.address[DEPTH_LOG2:1];
  assign unused_addr_c = ^{bus.address[ADDR_W-1:DEPTH_LOG2+1], bus.address[0]};

`ifdef FLASH_WRITE_PROTECT_EN
  logic wp_hit_q;

  // Sticky record of write protect seen since the request was accepted.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      wp_hit_q <= 1'b0;
    end else if (latch_c) begin
      wp_hit_q <= !wp_n;
    end else if (state_q == WAIT) begin
      wp_hit_q <= wp_hit_q || !wp_n;
    end
  end
`endif

  flash_wait_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .nRESET   (nRESET),
    .load     (cnt_load_c),
    .load_val (CNT_W'(WAIT_STATES)),
    .dec      (cnt_dec_c),
    .done_c   (cnt_done_c)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state, counter control and access decode; zero wait states access straight from the bus.
  always_comb begin
    state_d     = state_q;
    latch_c     = 1'b0;
    cnt_load_c  = 1'b0;
    cnt_dec_c   = 1'b0;
    acc_c       = 1'b0;
    err_d       = 1'b0;
    mem_we_c    = 1'b0;
    rd_c        = 1'b0;
    prot_c      = 1'b0;
    acc_idx_c   = idx_q;
    acc_we_c    = we_q;
    acc_wdata_c = wdata_q;

    case (state_q)
      IDLE: begin
        acc_idx_c   = bus_idx_c;
        acc_we_c    = bus.we;
        acc_wdata_c = bus.wdata;
        if (bus.req && sel_c) begin
          latch_c    = 1'b1;
          cnt_load_c = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            acc_c   = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (bus.req && multi_c) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        if (!sel_c) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cnt_done_c) begin
          state_d = RESP;
          acc_c   = 1'b1;
        end else begin
          cnt_dec_c = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef FLASH_WRITE_PROTECT_EN
    prot_c = (state_q == IDLE) ? !wp_n : (wp_hit_q || !wp_n);
`endif
    mem_we_c = acc_c && acc_we_c && !prot_c;
    rd_c     = acc_c && !acc_we_c;
    if (acc_c && acc_we_c && prot_c) err_d = 1'b1;
  end

  // Registered outputs and the request latch.
  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= acc_c;
      busy_q  <= (state_d != IDLE);
      err_q   <= err_d;
      if (latch_c) begin
        idx_q   <= bus_idx_c;
        we_q    <= bus.we;
        wdata_q <= bus.wdata;
      end
      if (rd_c) rdata_q <= mem[acc_idx_c];
    end
  end

  // Word array: not reset, so contents survive nRESET.
  always_ff @(posedge clk) begin
    if (nRESET && mem_we_c) mem[acc_idx_c] <= acc_wdata_c;
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_flash_chip_responder.sv
// Directed bench for flash_chip_responder: one instance with 3 wait states, one with none.
module tb_flash_chip_responder;
  import flash_map_pkg::*;

  logic        clk = 1'b0;
  logic        nRESET;
  logic [15:0] cs_n;
  logic [31:0] address;
  logic        req;
  logic        we;
  logic [15:0] wdata;
  logic        use0;
`ifdef FLASH_WRITE_PROTECT_EN
  logic        wp_n;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  flash_chip_responder_if #(.CS_W(16), .ADDR_W(32), .DATA_W(16)) b3 ();
  flash_chip_responder_if #(.CS_W(16), .ADDR_W(32), .DATA_W(16)) b0 ();

  assign b3.cs_n = cs_n;  assign b3.address = address;  assign b3.req = req;
  assign b3.we   = we;    assign b3.wdata   = wdata;
  assign b0.cs_n = cs_n;  assign b0.address = address;  assign b0.req = req;
  assign b0.we   = we;    assign b0.wdata   = wdata;

  flash_chip_responder #(.WAIT_STATES(3), .CS_INDEX(FLASH0_IDX)) dut3 (
    .clk    (clk),
    .nRESET (nRESET),
`ifdef FLASH_WRITE_PROTECT_EN
    .wp_n   (wp_n),
`endif
    .bus    (b3.slave)
  );

  flash_chip_responder #(.WAIT_STATES(0), .CS_INDEX(FLASH0_IDX)) dut0 (
    .clk    (clk),
    .nRESET (nRESET),
`ifdef FLASH_WRITE_PROTECT_EN
    .wp_n   (wp_n),
`endif
    .bus    (b0.slave)
  );

  // Observed outputs of whichever instance is under test.
  logic        obs_ready, obs_busy, obs_err;
  logic [15:0] obs_rdata;
  assign obs_ready = use0 ? b0.ready : b3.ready;
  assign obs_busy  = use0 ? b0.busy  : b3.busy;
  assign obs_err   = use0 ? b0.err   : b3.err;
  assign obs_rdata = use0 ? b0.rdata : b3.rdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; waits (bounded) for ready or err and reports the cycle count after the sampling edge.
  task automatic access(input logic wr, input logic [31:0] a, input logic [15:0] d,
                        input logic [15:0] cs, output int lat, output logic got_rdy,
                        output logic got_err, output logic [15:0] rd, output logic busy_seen);
    @(negedge clk);
    cs_n = cs; address = a; we = wr; wdata = d; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    lat = 0; got_rdy = 1'b0; got_err = 1'b0; rd = '0; busy_seen = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) @(negedge clk);
      busy_seen = busy_seen | obs_busy;
      if (obs_ready || obs_err) begin
        lat = n; got_rdy = obs_ready; got_err = obs_err; rd = obs_rdata;
        break;
      end
    end
    cs_n = CS_NONE;
  endtask

  int          lat;
  logic        rdy, er, bz;
  logic [15:0] rd;

  initial begin
    nRESET = 1'b0; cs_n = CS_NONE; address = '0; req = 1'b0; we = 1'b0; wdata = '0; use0 = 1'b0;
`ifdef FLASH_WRITE_PROTECT_EN
    wp_n = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(obs_ready), 32'd0);
    check("rst_busy",  32'(obs_busy),  32'd0);
    check("rst_err",   32'(obs_err),   32'd0);
    check("rst_rdata", 32'(obs_rdata), 32'd0);
    nRESET = 1'b1;

    // Write then read back with 3 wait states.
    access(1'b1, 32'h0000_0010, 16'hBEEF, 16'hFFFE, lat, rdy, er, rd, bz);
    check("wr_lat", 32'(lat), 32'd4);
    check("wr_rdy", 32'(rdy), 32'd1);
    check("wr_err", 32'(er),  32'd0);
    access(1'b0, 32'h0000_0010, 16'h0000, 16'hFFFE, lat, rdy, er, rd, bz);
    check("rd_lat",   32'(lat), 32'd4);
    check("rd_rdata", 32'(rd),  32'hBEEF);
    @(negedge clk);
    check("rd_pulse", 32'(obs_ready), 32'd0);
    check("rd_hold",  32'(obs_rdata), 32'hBEEF);

    // Aliased address reaches the same word.
    access(1'b0, 32'h1000_0011, 16'h0000, 16'hFFFE, lat, rdy, er, rd, bz);
    check("alias_rdata", 32'(rd), 32'hBEEF);

    // Other chip selected: ignored.
    access(1'b1, 32'h0000_0010, 16'h1111, 16'hFFFD, lat, rdy, er, rd, bz);
    check("other_rdy",  32'(rdy), 32'd0);
    check("other_err",  32'(er),  32'd0);
    check("other_busy", 32'(bz),  32'd0);

    // Two chips selected: one-cycle error, no access.
    access(1'b1, 32'h0000_0010, 16'h2222, 16'hFFFC, lat, rdy, er, rd, bz);
    check("multi_err", 32'(er),  32'd1);
    check("multi_rdy", 32'(rdy), 32'd0);
    check("multi_lat", 32'(lat), 32'd1);
    @(negedge clk);
    check("multi_err_pulse", 32'(obs_err), 32'd0);
    access(1'b0, 32'h0000_0010, 16'h0000, 16'hFFFE, lat, rdy, er, rd, bz);
    check("multi_keep", 32'(rd), 32'hBEEF);

    // Deselect during WAIT aborts the read.
    @(negedge clk);
    cs_n = 16'hFFFE; address = 32'h0000_0010; we = 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    cs_n = 16'hFFFF;
    @(negedge clk);
    check("abort_err",  32'(obs_err),   32'd1);
    check("abort_rdy",  32'(obs_ready), 32'd0);
    check("abort_busy", 32'(obs_busy),  32'd0);
    @(negedge clk);
    check("abort_err_pulse", 32'(obs_err), 32'd0);
    access(1'b0, 32'h0000_0010, 16'h0000, 16'hFFFE, lat, rdy, er, rd, bz);
    check("abort_next_lat", 32'(lat), 32'd4);
    check("abort_next_rd",  32'(rd),  32'hBEEF);

    // Reset during WAIT of a write leaves the old word.
    access(1'b1, 32'h0000_0020, 16'hAAAA, 16'hFFFE, lat, rdy, er, rd, bz);
    check("aaaa_rdy", 32'(rdy), 32'd1);
    @(negedge clk);
    cs_n = 16'hFFFE; address = 32'h0000_0020; we = 1'b1; wdata = 16'h1234; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    nRESET = 1'b0;
    #1;
    check("mid_rst_ready", 32'(obs_ready), 32'd0);
    check("mid_rst_busy",  32'(obs_busy),  32'd0);
    check("mid_rst_err",   32'(obs_err),   32'd0);
    check("mid_rst_rdata", 32'(obs_rdata), 32'd0);
    @(negedge clk);
    nRESET = 1'b1; cs_n = CS_NONE;
    access(1'b0, 32'h0000_0020, 16'h0000, 16'hFFFE, lat, rdy, er, rd, bz);
    check("mid_rst_keep", 32'(rd), 32'hAAAA);

    // Zero wait states: ready in the cycle after req, requests every 2 cycles.
    use0 = 1'b1;
    access(1'b1, 32'h0000_0004, 16'h0042, 16'hFFFE, lat, rdy, er, rd, bz);
    check("ws0_wr_lat", 32'(lat), 32'd1);
    access(1'b0, 32'h0000_0004, 16'h0000, 16'hFFFE, lat, rdy, er, rd, bz);
    check("ws0_rd_lat", 32'(lat), 32'd1);
    check("ws0_rd",     32'(rd),  32'h0042);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cs_n = 16'hFFFE; address = 32'h0000_0040 + 32'(2 * i); we = 1'b1; wdata = 16'hC000 + 16'(i); req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("b2b_wr_rdy", 32'(obs_ready), 32'd1);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cs_n = 16'hFFFE; address = 32'h0000_0040 + 32'(2 * i); we = 1'b0; req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("b2b_rd_rdy", 32'(obs_ready), 32'd1);
      check("b2b_rd",     32'(obs_rdata), 32'hC000 + 32'(i));
    end
    cs_n = CS_NONE;
    use0 = 1'b0;
    repeat (6) @(negedge clk);

`ifdef FLASH_WRITE_PROTECT_EN
    // Protected write completes with ready and err together, array unchanged.
    wp_n = 1'b0;
    access(1'b1, 32'h0000_0010, 16'h5555, 16'hFFFE, lat, rdy, er, rd, bz);
    check("wp_lat", 32'(lat), 32'd4);
    check("wp_rdy", 32'(rdy), 32'd1);
    check("wp_err", 32'(er),  32'd1);
    wp_n = 1'b1;
    access(1'b0, 32'h0000_0010, 16'h0000, 16'hFFFE, lat, rdy, er, rd, bz);
    check("wp_keep",   32'(rd), 32'hBEEF);
    check("wp_rd_err", 32'(er), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
